// File: rtl/chk_pkg.sv
// Shared definitions for the shift-register chip checker.
//   chk_state_e : checker FSM states
//   Pin*        : chip_in pin offsets above the WIDTH parallel-data pins
//   next_q0     : J/K_N serial-input function of the chip's first stage
package chk_pkg;

  typedef enum logic [1:0] {
    Halted = 2'd0,
    Set    = 2'd1,
    Test   = 2'd2,
    Done_s = 2'd3
  } chk_state_e;

  // chip_in layout: [WIDTH-1:0] parallel data, then the pins below at WIDTH + offset.
  localparam int unsigned PinShLdN = 0;
  localparam int unsigned PinJ     = 1;
  localparam int unsigned PinKN    = 2;
  localparam int unsigned PinClrN  = 3;
  localparam int unsigned PinCclk  = 4;

  // J/K_N: 00 -> 0, 01 -> hold, 10 -> toggle, 11 -> 1
  function automatic logic next_q0(input logic j, input logic k_n, input logic q0);
    logic r;
    unique case ({j, k_n})
      2'b00:   r = 1'b0;
      2'b01:   r = q0;
      2'b10:   r = ~q0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shreg_ref_model.sv
// Golden model of the shift register under test.
// Ports:
//   Clk, Reset      : system clock, async active-high reset (clears q)
//   update          : one-cycle strobe marking the chip-clock rising edge
//   clr_n, sh_ld_n  : clear and shift/load controls (active low)
//   j, k_n, data    : serial-input controls and parallel load data
//   q, q_n          : model register and complement of its top bit
module shreg_ref_model
  import chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             update,
  input  logic             clr_n,
  input  logic             sh_ld_n,
  input  logic             j,
  input  logic             k_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             q_n
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q <= '0;
    end else if (update) begin
      if (!clr_n) begin
        q_q <= '0;
      end else if (!sh_ld_n) begin
        q_q <= data;
      end else begin
        q_q <= {q_q[WIDTH-2:0], next_q0(j, k_n, q_q[0])};
      end
    end
  end

  assign q   = q_q;
  assign q_n = ~q_q[WIDTH-1];

endmodule

// File: rtl/shreg_chip_checker.sv
// Exhaustive functional tester for a WIDTH-bit shift-register chip.
// Sweeps every combination of data/control pins once, clocking the chip once per
// vector, and compares the chip's outputs with a golden model.
// Ports:
//   Clk, Reset : system clock, async active-high reset
//   Run        : start request (sampled in Halted)
//   DISP_RSLT  : result acknowledge (sampled in Done_s)
//   chip_in    : stimulus pins {CCLK, CLR_N, K_N, J, SH_LD_N, data}
//   chip_q     : sensed pins {~Q[WIDTH-1], Q}
//   Done       : high while the result is waiting for acknowledge
//   RSLT       : 1 = chip passed last run
// Optional build macro SHREG_CHK_FAIL_LOG_EN adds fail_vec (first failing vector)
// and fail_cnt (saturating count of failing vectors).
module shreg_chip_checker
  import chk_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             DISP_RSLT,
  output logic [WIDTH+4:0] chip_in,
  input  logic [WIDTH:0]   chip_q,
  output logic             Done,
  output logic             RSLT
`ifdef SHREG_CHK_FAIL_LOG_EN
  ,
  output logic [WIDTH+3:0] fail_vec,
  output logic [7:0]       fail_cnt
`endif
);

  localparam int unsigned VW = WIDTH + 4;
  localparam logic [4:0] PhLowLast = 5'(SETTLE - 1);
  localparam logic [4:0] PhHigh    = 5'(SETTLE);
  localparam logic [4:0] PhLast    = 5'(2 * SETTLE - 1);

  chk_state_e       state_q;
  logic [VW-1:0]    v_q;
  logic [4:0]       ph_q;
  logic             rslt_q;
  logic             done_q;
  logic [WIDTH+4:0] chip_in_q;
`ifdef SHREG_CHK_FAIL_LOG_EN
  logic [VW-1:0]    fail_vec_q;
  logic [7:0]       fail_cnt_q;
`endif

  logic             ph_wrap;
  logic [4:0]       ph_next;
  logic [VW-1:0]    v_next;
  logic             cclk_next;
  logic             update;
  logic             mismatch;
  logic [WIDTH-1:0] model_q;
  logic             model_qn;

  always_comb begin
    ph_wrap   = (ph_q == PhLast);
    ph_next   = ph_wrap ? 5'd0 : ph_q + 5'd1;
    v_next    = ph_wrap ? v_q + VW'(1) : v_q;
    cclk_next = (ph_next >= PhHigh);
    // Model steps on the edge that raises CCLK, in step with the chip.
    update    = (state_q == Test) && (ph_q == PhLowLast);
    // Compare in the last cycle of the high phase, after the chip has settled.
    mismatch  = (state_q == Test) && ph_wrap && (chip_q != {model_qn, model_q});
  end

  shreg_ref_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .Clk     (Clk),
    .Reset   (Reset),
    .update  (update),
    .clr_n   (v_q[WIDTH+PinClrN]),
    .sh_ld_n (v_q[WIDTH+PinShLdN]),
    .j       (v_q[WIDTH+PinJ]),
    .k_n     (v_q[WIDTH+PinKN]),
    .data    (v_q[WIDTH-1:0]),
    .q       (model_q),
    .q_n     (model_qn)
  );

  // chip_in is registered: each branch loads the pin value for the next cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= Halted;
      v_q        <= '0;
      ph_q       <= '0;
      rslt_q     <= 1'b0;
      done_q     <= 1'b0;
      chip_in_q  <= '0;
`ifdef SHREG_CHK_FAIL_LOG_EN
      fail_vec_q <= '0;
      fail_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        Halted: begin
          chip_in_q <= '0;
          done_q    <= 1'b0;
          if (Run) begin
            state_q <= Set;
          end
        end
        Set: begin
          v_q        <= '0;
          ph_q       <= '0;
          rslt_q     <= 1'b1;
          chip_in_q  <= '0; // first vector: V=0, CCLK low
          state_q    <= Test;
`ifdef SHREG_CHK_FAIL_LOG_EN
          fail_vec_q <= '0;
          fail_cnt_q <= '0;
`endif
        end
        Test: begin
          ph_q <= ph_next;
          v_q  <= v_next;
`ifdef SHREG_CHK_FAIL_LOG_EN
          if (mismatch) begin
            rslt_q <= 1'b0;
            if (fail_cnt_q == 8'd0) begin
              fail_vec_q <= v_q;
            end
            if (fail_cnt_q != 8'hFF) begin
              fail_cnt_q <= fail_cnt_q + 8'd1;
            end
          end
`else
          if (mismatch) begin
            rslt_q <= 1'b0;
          end
`endif
          if (ph_wrap && (&v_q)) begin
            state_q   <= Done_s;
            chip_in_q <= '0;
            done_q    <= 1'b1;
          end else begin
            chip_in_q <= {cclk_next, v_next};
          end
        end
        Done_s: begin
          chip_in_q <= '0;
          if (DISP_RSLT) begin
            state_q <= Halted;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= Halted;
          chip_in_q <= '0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign chip_in = chip_in_q;
  assign Done    = done_q;
  assign RSLT    = rslt_q;
`ifdef SHREG_CHK_FAIL_LOG_EN
  assign fail_vec = fail_vec_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule
